mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4, beats in a read burst (instruction fetch of one 32-bit word as 4 bytes).
REQ-002 Parameter ADDR_W, default 16, byte-address width on all address ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  transaction request from core 0 / core 1, held high until doneN is seen.
REQ-006 we0 / we1  input  1  1 = byte write, 0 = read; sampled at grant.
REQ-007 burst0 / burst1  input  1  1 = BURST_LEN-beat read, 0 = single beat; ignored (forced single) when weN=1.
REQ-008 addr0 / addr1  input  ADDR_W  start byte address; sampled at grant.
REQ-009 wdata0 / wdata1  input  8  write byte; held stable by requester until doneN.
REQ-010 ack0 / ack1  output  1  one-cycle pulse per completed beat.
REQ-011 rdata0 / rdata1  output  8  registered read byte, valid while ackN=1, holds value otherwise.
REQ-012 done0 / done1  output  1  one-cycle pulse with the final ack of a transaction.
REQ-013 mem_addr  output  ADDR_W  address to shared byte memory.
REQ-014 mem_wdata  output  8  write byte to memory.
REQ-015 mem_read / mem_write  output  1  memory read enable (combinational read data) / write enable (written on rising edge).
REQ-016 mem_rdata  input  8  memory read data, valid same cycle as mem_read.

Function
REQ-017 FSM states IDLE, XFER, TURN; state, owner, base address, beat counter, rr pointer all registered.
REQ-018 IDLE: if neither req high, stay IDLE; if one high, grant it; if both high, grant core not marked by rr pointer (last-served), then next edge -> XFER.
REQ-019 At grant: latch owner, base=addrN, we, beat count (1 or BURST_LEN), beat=0; rr pointer <= owner.
REQ-020 XFER: mem_addr = base + beat, modulo 2^ADDR_W (0xFFFF wraps to 0x0000); mem_read = ~we; mem_write = we; mem_wdata = owner's wdata.
REQ-021 XFER each edge: rdataN <= mem_rdata (reads only), ackN <= 1 for owner, beat increments.
REQ-022 Last beat edge: doneN <= 1 together with ackN, state -> TURN.
REQ-023 TURN: one cycle, no memory access, both reqs ignored; next edge -> IDLE.
REQ-024 Single read latency: req seen in IDLE cycle 0, XFER cycle 1, ack/done/rdata visible cycle 2, IDLE cycle 3.
REQ-025 Burst read: XFER cycles 1..BURST_LEN, acks cycles 2..BURST_LEN+1, done with last ack.
REQ-026 Outside XFER: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-027 Non-owner ack/done never asserted; never both acks high in one cycle.
REQ-028 reqN dropped mid-transaction: transaction completes; no abort.
REQ-029 Back-to-back: core holding req continuously while other core also requests alternates strictly with it.

Reset
REQ-030 reset high: immediately state=IDLE, beat=0, all acks/dones=0, rdata0/rdata1=0, memory outputs 0, rr pointer=core 1 (core 0 wins first tie).
REQ-031 reset asserted mid-burst: burst abandoned, no further ack/done, no memory write issued after reset asserts.
REQ-032 After reset release, first rising edge with a req high performs a normal grant.

Verification
REQ-033 Single read: mem[0x0010]=0xA5, req0=1 we0=0 burst0=0 addr0=0x0010 -> cycle 2 ack0=1 done0=1 rdata0=0xA5; ack1 stays 0.
REQ-034 Burst read: mem[0x20..0x23]=00,01,02,03, req1 burst1=1 -> mem_addr 0x20..0x23 cycles 1-4, ack1 cycles 2-5 with rdata1 00..03, done1 cycle 5 only.
REQ-035 Simultaneous reqs after reset, both held -> grant order core0, core1, core0; TURN cycle between each; no overlapping acks.
REQ-036 Write: req1 we1=1 addr1=0x0102 wdata1=0x3C -> mem_write=1 one cycle with mem_addr=0x0102 mem_wdata=0x3C; later read returns 0x3C.
REQ-037 Wrap: burst read at addr 0xFFFE -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-038 Reset during beat 2 of burst -> ack/done low next cycle onward, mem_read=0, FSM IDLE, next req0 served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port byte memory.
// Round-robin on ties, single-beat writes, single or BURST_LEN-beat reads.
module mem_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              burst0,
  input  logic              burst1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [7:0]        rdata0,
  output logic [7:0]        rdata1,
  output logic              done0,
  output logic              done1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [7:0]        mem_rdata
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic [BW-1:0]       last_q, last_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                rr_q, rr_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          done_q, done_d;
  logic [7:0]          rdata0_q, rdata0_d;
  logic [7:0]          rdata1_q, rdata1_d;
  logic                grant;
  logic                grant_we;
  logic                grant_burst;

  // rr_q remembers the last core served; a tie goes to the other one.
  assign grant       = (req0 && req1) ? ~rr_q : req1;
  assign grant_we    = grant ? we1 : we0;
  assign grant_burst = grant ? burst1 : burst0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    base_d    = base_q;
    we_d      = we_q;
    last_d    = last_q;
    beat_d    = beat_q;
    rr_d      = rr_q;
    ack_d     = 2'b00;
    done_d    = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = grant;
          base_d  = grant ? addr1 : addr0;
          we_d    = grant_we;
          last_d  = (!grant_we && grant_burst) ? BW'(BURST_LEN - 1) : '0;
          beat_d  = '0;
          rr_d    = grant;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        mem_addr       = base_q + ADDR_W'(beat_q);
        mem_read       = ~we_q;
        mem_write      = we_q;
        mem_wdata      = owner_q ? wdata1 : wdata0;
        ack_d[owner_q] = 1'b1;
        if (!we_q) begin
          if (owner_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
        end
        beat_d = beat_q + BW'(1);
        if (beat_q == last_q) begin
          done_d[owner_q] = 1'b1;
          beat_d          = '0;
          state_d         = ST_TURN;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      base_q   <= '0;
      we_q     <= 1'b0;
      last_q   <= '0;
      beat_q   <= '0;
      rr_q     <= 1'b1;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      base_q   <= base_d;
      we_q     <= we_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      rr_q     <= rr_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0   = ack_q[0];
  assign ack1   = ack_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// transactions checked against a transaction-level arbitration/memory model.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1, burst0, burst1;
  logic [AW-1:0] addr0, addr1;
  logic [7:0]    wdata0, wdata1;
  logic          ack0, ack1, done0, done1;
  logic [7:0]    rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_read, mem_write;
  logic [7:0]    mem_rdata;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] exp_rd  [2];
  int         rr_last;
  int         vecs = 0;
  int         errs = 0;

  mem_arbiter #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .burst0(burst0), .burst1(burst1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .done0(done0), .done1(done1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; burst0 = 0; burst1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = 8'h00; wdata1 = 8'h00;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    rr_last = 1;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  endtask

  task automatic test_reset();
    logic [53:0] got;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req0 = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      got = {ack0, ack1, done0, done1, rdata0, rdata1, mem_read, mem_write, mem_addr, mem_wdata};
      vecs++;
      if (got !== 54'd0) begin
        errs++;
        $display("FAIL reset_outputs step %0d: got %h want 0", k, got);
      end
      step();
    end
    req0 = 1'b0;
    reset = 1'b0;
    rr_last = 1;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  endtask

  task automatic test_single_read();
    logic [21:0] got, exp;
    preload(16'h0010, 8'hA5);
    req0 = 1; we0 = 0; burst0 = 0; addr0 = 16'h0010;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 2) req0 = 0;
      got = {ack0, ack1, done0, done1, mem_read, mem_write, mem_addr};
      exp = {k == 2, 1'b0, k == 2, 1'b0, k == 1, 1'b0, (k == 1) ? 16'h0010 : 16'h0000};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL single_read cycle %0d: got %h want %h", k, got, exp);
      end
    end
    vecs++;
    if (rdata0 !== 8'hA5) begin
      errs++;
      $display("FAIL single_read_rdata0: got %h want a5", rdata0);
    end
    rr_last = 0;
    idle_inputs();
  endtask

  task automatic test_burst_read();
    logic [21:0] got, exp;
    for (int i = 0; i < 4; i++) preload(16'h0020 + 16'(i), 8'(i));
    req1 = 1; we1 = 0; burst1 = 1; addr1 = 16'h0020;
    for (int k = 1; k <= BL + 2; k++) begin
      step();
      if (k == BL + 1) req1 = 0;
      got = {ack0, ack1, done0, done1, mem_read, mem_write, mem_addr};
      exp = {1'b0, (k >= 2) && (k <= BL + 1), 1'b0, k == BL + 1, k <= BL, 1'b0,
             (k <= BL) ? 16'h0020 + 16'(k - 1) : 16'h0000};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL burst_read cycle %0d: got %h want %h", k, got, exp);
      end
      if (k >= 2 && k <= BL + 1) begin
        vecs++;
        if (rdata1 !== 8'(k - 2)) begin
          errs++;
          $display("FAIL burst_rdata1 cycle %0d: got %h want %h", k, rdata1, 8'(k - 2));
        end
      end
    end
    rr_last = 1;
    idle_inputs();
  endtask

  task automatic test_write_then_read();
    logic [24:0] got, exp;
    req1 = 1; we1 = 1; burst1 = 1; addr1 = 16'h0102; wdata1 = 8'h3C;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 2) req1 = 0;
      got = {ack1, done1, mem_read, mem_write, mem_addr, mem_wdata};
      exp = {k == 2, k == 2, 1'b0, k == 1, (k == 1) ? 16'h0102 : 16'h0000, (k == 1) ? 8'h3C : 8'h00};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL write cycle %0d: got %h want %h", k, got, exp);
      end
    end
    ref_mem[16'h0102] = 8'h3C;
    idle_inputs();
    req0 = 1; addr0 = 16'h0102;
    step();
    step();
    req0 = 0;
    vecs++;
    if ({ack0, done0, rdata0} !== {1'b1, 1'b1, ref_mem[16'h0102]}) begin
      errs++;
      $display("FAIL write_readback: got ack=%b done=%b rdata=%h want 1 1 3c", ack0, done0, rdata0);
    end
    step();
    rr_last = 0;
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    req0 = 1; we0 = 0; burst0 = 1; addr0 = 16'hFFFE;
    for (int k = 1; k <= BL + 2; k++) begin
      step();
      if (k == BL + 1) req0 = 0;
      ea = (k <= BL) ? 16'hFFFE + 16'(k - 1) : 16'h0000;
      vecs++;
      if (mem_addr !== ea || mem_read !== (k <= BL)) begin
        errs++;
        $display("FAIL wrap_addr cycle %0d: got %h rd=%b want %h", k, mem_addr, mem_read, ea);
      end
      if (k >= 2 && k <= BL + 1) begin
        vecs++;
        if (rdata0 !== ref_mem[16'hFFFE + 16'(k - 2)] || ack0 !== 1'b1) begin
          errs++;
          $display("FAIL wrap_rdata cycle %0d: got %h ack=%b want %h", k, rdata0, ack0,
                   ref_mem[16'hFFFE + 16'(k - 2)]);
        end
      end
    end
    rr_last = 0;
    idle_inputs();
  endtask

  task automatic test_tie_order();
    logic [21:0] got, exp;
    int          owner, phase;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 16'h0100; addr1 = 16'h0200;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 8) begin req0 = 0; req1 = 0; end
      owner = ((k - 1) / 3) % 2;
      phase = (k - 1) % 3;
      got = {ack0, ack1, done0, done1, mem_read, mem_write, mem_addr};
      exp = {phase == 1 && owner == 0, phase == 1 && owner == 1,
             phase == 1 && owner == 0, phase == 1 && owner == 1,
             phase == 0, 1'b0,
             (phase == 0) ? ((owner == 1) ? 16'h0200 : 16'h0100) : 16'h0000};
      vecs++;
      if (got !== exp) begin
        errs++;
        $display("FAIL tie_order cycle %0d: got %h want %h", k, got, exp);
      end
    end
    rr_last = 0;
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    logic [35:0] got;
    req1 = 1; burst1 = 1; addr1 = 16'h0040;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      got = {ack0, ack1, done0, done1, mem_read, mem_write, mem_addr, rdata1};
      vecs++;
      if (got !== 36'd0) begin
        errs++;
        $display("FAIL reset_mid_burst step %0d: got %h want 0", k, got);
      end
      step();
    end
    reset = 1'b0;
    rr_last = 1;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    idle_inputs();
    preload(16'h0050, 8'h5A);
    req0 = 1; addr0 = 16'h0050;
    step();
    vecs++;
    if ({mem_read, mem_addr, ack1} !== {1'b1, 16'h0050, 1'b0}) begin
      errs++;
      $display("FAIL post_reset_grant: got rd=%b addr=%h ack1=%b want 1 0050 0", mem_read, mem_addr, ack1);
    end
    step();
    req0 = 0;
    vecs++;
    if ({ack0, done0, ack1, done1, rdata0} !== {4'b1100, 8'h5A}) begin
      errs++;
      $display("FAIL post_reset_read: got %b%b%b%b %h want 1100 5a", ack0, done0, ack1, done1, rdata0);
    end
    step();
    rr_last = 0;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [21:0]   got, exp;
    logic [AW-1:0] a [2];
    logic [7:0]    d [2];
    logic          wr [2];
    logic          bu [2];
    logic [AW-1:0] ea;
    logic [1:0]    p;
    int            w, nb;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      p = 2'($urandom_range(1, 3));
      for (int c = 0; c < 2; c++) begin
        wr[c] = ($urandom_range(0, 3) == 0);
        bu[c] = $urandom_range(0, 1) != 0;
        a[c]  = ($urandom_range(0, 5) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
        d[c]  = 8'($urandom);
      end
      req0 = p[0]; we0 = wr[0]; burst0 = bu[0]; addr0 = a[0]; wdata0 = d[0];
      req1 = p[1]; we1 = wr[1]; burst1 = bu[1]; addr1 = a[1]; wdata1 = d[1];
      w  = (p == 2'b11) ? 1 - rr_last : (p[1] ? 1 : 0);
      rr_last = w;
      nb = (!wr[w] && bu[w]) ? BL : 1;
      for (int k = 1; k <= nb + 1; k++) begin
        step();
        if (k == nb + 1) begin req0 = 0; req1 = 0; end
        ea = (k <= nb) ? a[w] + 16'(k - 1) : 16'h0000;
        if (k >= 2 && !wr[w]) exp_rd[w] = ref_mem[a[w] + 16'(k - 2)];
        got = {ack0, ack1, done0, done1, mem_read, mem_write, mem_addr};
        exp = {w == 0 && k >= 2, w == 1 && k >= 2, w == 0 && k == nb + 1, w == 1 && k == nb + 1,
               k <= nb && !wr[w], k <= nb && wr[w], ea};
        vecs++;
        if (got !== exp) begin
          errs++;
          $display("FAIL random it %0d cycle %0d: got %h want %h", it, k, got, exp);
        end
        vecs++;
        if ({rdata0, rdata1} !== {exp_rd[0], exp_rd[1]}) begin
          errs++;
          $display("FAIL random_rdata it %0d cycle %0d: got %h %h want %h %h", it, k,
                   rdata0, rdata1, exp_rd[0], exp_rd[1]);
        end
        if (k <= nb && wr[w]) begin
          vecs++;
          if (mem_wdata !== d[w]) begin
            errs++;
            $display("FAIL random_wdata it %0d: got %h want %h", it, mem_wdata, d[w]);
          end
        end
      end
      if (wr[w]) ref_mem[a[w]] = d[w];
      step();
    end
    idle_inputs();
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    idle_inputs();
    test_reset();
    test_single_read();
    test_burst_read();
    test_write_then_read();
    test_wrap();
    test_tie_order();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
